// File: rtl/wasca_spi_pkg.sv
// rtl/wasca_spi_pkg.sv - register map, status/control bit positions and constants for the wasca SPI slave
package wasca_spi_pkg;
    localparam int DATABITS = 16;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;
    localparam logic [2:0] ADDR_EOP     = 3'd6;

    localparam int ST_SEL  = 10;
    localparam int ST_EOP  = 9;
    localparam int ST_E    = 8;
    localparam int ST_RRDY = 7;
    localparam int ST_TRDY = 6;
    localparam int ST_TMT  = 5;
    localparam int ST_TOE  = 4;
    localparam int ST_ROE  = 3;
    localparam int ST_TUR  = 2;

    localparam logic [DATABITS-1:0] UNDERRUN_FILL = 16'hFFFF;

`ifdef SPI_SLAVE_EOP_EN
    localparam logic [DATABITS-1:0] CTRL_MASK = 16'h03DC;
`else
    localparam logic [DATABITS-1:0] CTRL_MASK = 16'h01DC;
`endif
endpackage

// File: rtl/wasca_spi_slave_if.sv
// rtl/wasca_spi_slave_if.sv - Avalon-style CPU register port of the wasca SPI slave
interface wasca_spi_slave_if;
    import wasca_spi_pkg::*;
    logic                spi_select;
    logic [2:0]          mem_addr;
    logic                read_n;
    logic                write_n;
    logic [DATABITS-1:0] data_from_cpu;
    logic [DATABITS-1:0] data_to_cpu;
    logic                irq;
    logic                dataavailable;
    logic                readyfordata;
    logic                endofpacket;

    modport master (
        output spi_select, mem_addr, read_n, write_n, data_from_cpu,
        input  data_to_cpu, irq, dataavailable, readyfordata, endofpacket
    );
    modport slave (
        input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
        output data_to_cpu, irq, dataavailable, readyfordata, endofpacket
    );
endinterface

// File: rtl/wasca_spi_slave_sync.sv
// rtl/wasca_spi_slave_sync.sv - 2-flop synchronizer plus edge-detect flop with rise/fall pulses
module wasca_spi_slave_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic meta, sync, prev;

    // Resets low so a select already asserted at reset release yields no fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/wasca_spi_slave.sv
// rtl/wasca_spi_slave.sv - SPI mode-0 slave with CPU register port; SPI_SLAVE_EOP_EN enables end-of-packet
module wasca_spi_slave import wasca_spi_pkg::*; (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              SCLK,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    wasca_spi_slave_if.slave  bus
);
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic mosi_meta, mosi_s;

    wasca_spi_slave_sync u_sclk (.clk(clk), .reset_n(reset_n), .din(SCLK), .rise(sclk_rise), .fall(sclk_fall));
    wasca_spi_slave_sync u_ss   (.clk(clk), .reset_n(reset_n), .din(SS_n), .rise(ss_rise),   .fall(ss_fall));

    logic [DATABITS-1:0] shift_reg, tx_holding, rx_holding, control, wdata_q, rd_data, status, data_to_cpu_r, next_word;
    logic [4:0]          bitcount;
    logic [2:0]          addr_q;
    logic rx_bit, busy, sel, tx_primed, rrdy, roe, toe, tur, eop, irq_r;
    logic rd_req, wr_req, rd_req_d, wr_req_d, rd_pulse, wr_pulse;
    logic rx_read, tx_write, st_write, word_start, word_done;

    assign rd_req     = bus.spi_select & ~bus.read_n;
    assign wr_req     = bus.spi_select & ~bus.write_n;
    assign rx_read    = rd_pulse && (addr_q == ADDR_RXDATA);
    assign tx_write   = wr_pulse && (addr_q == ADDR_TXDATA);
    assign st_write   = wr_pulse && (addr_q == ADDR_STATUS);
    assign word_start = ss_fall | (busy & sclk_fall & (bitcount == 5'd16));
    assign word_done  = busy & sclk_rise & (bitcount == 5'd15);
    // A txdata write landing on an empty holding register at word start goes straight out.
    assign next_word  = tx_primed ? tx_holding : (tx_write ? wdata_q : UNDERRUN_FILL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
            rd_req_d  <= 1'b0;
            wr_req_d  <= 1'b0;
            rd_pulse  <= 1'b0;
            wr_pulse  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            mosi_meta <= MOSI;
            mosi_s    <= mosi_meta;
            rd_req_d  <= rd_req;
            wr_req_d  <= wr_req;
            rd_pulse  <= rd_req & ~rd_req_d;
            wr_pulse  <= wr_req & ~wr_req_d;
            if ((rd_req & ~rd_req_d) | (wr_req & ~wr_req_d)) begin
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.data_from_cpu;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
            rx_bit    <= 1'b0;
            bitcount  <= '0;
            busy      <= 1'b0;
            sel       <= 1'b0;
            MISO      <= 1'b1;
            MISO_oe   <= 1'b0;
        end else begin
            if (ss_fall) sel <= 1'b1;
            if (ss_rise) sel <= 1'b0;
            if (ss_rise) begin
                busy     <= 1'b0;
                bitcount <= '0;
                MISO     <= 1'b1;
                MISO_oe  <= 1'b0;
            end else if (word_start) begin
                shift_reg <= next_word;
                MISO      <= next_word[DATABITS-1];
                MISO_oe   <= 1'b1;
                busy      <= 1'b1;
                bitcount  <= '0;
            end else if (busy & sclk_rise) begin
                rx_bit   <= mosi_s;
                bitcount <= bitcount + 5'd1;
            end else if (busy & sclk_fall) begin
                // Received bits enter at the bottom as transmit bits leave the top.
                shift_reg <= {shift_reg[DATABITS-2:0], rx_bit};
                MISO      <= shift_reg[DATABITS-2];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_holding <= '0;
            tx_primed  <= 1'b0;
            rx_holding <= '0;
            rrdy       <= 1'b0;
            roe        <= 1'b0;
            toe        <= 1'b0;
            tur        <= 1'b0;
            control    <= '0;
        end else begin
            if (word_start) begin
                tx_primed <= tx_primed & tx_write;
                if (tx_primed & tx_write) tx_holding <= wdata_q;
            end else if (tx_write & ~tx_primed) begin
                tx_primed  <= 1'b1;
                tx_holding <= wdata_q;
            end
            if (st_write) begin
                roe <= 1'b0;
                toe <= 1'b0;
                tur <= 1'b0;
            end
            if (rx_read | st_write) rrdy <= 1'b0;
            if (tx_write & tx_primed & ~word_start) toe <= 1'b1;
            if (word_start & ~tx_primed & ~tx_write) tur <= 1'b1;
            if (word_done) begin
                rx_holding <= {shift_reg[DATABITS-2:0], mosi_s};
                rrdy       <= 1'b1;
                if (rrdy & ~rx_read & ~st_write) roe <= 1'b1;
            end
            if (wr_pulse && (addr_q == ADDR_CONTROL)) control <= wdata_q & CTRL_MASK;
        end
    end

`ifdef SPI_SLAVE_EOP_EN
    logic [DATABITS-1:0] eop_val;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eop     <= 1'b0;
            eop_val <= '0;
        end else begin
            if (wr_pulse && (addr_q == ADDR_EOP)) eop_val <= wdata_q;
            if (st_write) eop <= 1'b0;
            if ((rx_read && (rx_holding == eop_val)) || (tx_write && (wdata_q == eop_val))) eop <= 1'b1;
        end
    end
`else
    assign eop = 1'b0;
`endif

    always_comb begin
        status          = '0;
        status[ST_SEL]  = sel;
        status[ST_EOP]  = eop;
        status[ST_E]    = roe | toe;
        status[ST_RRDY] = rrdy;
        status[ST_TRDY] = ~tx_primed;
        status[ST_TMT]  = ~tx_primed & ~busy;
        status[ST_TOE]  = toe;
        status[ST_ROE]  = roe;
        status[ST_TUR]  = tur;
    end

    always_comb begin
        rd_data = '0;
        case (addr_q)
            ADDR_RXDATA:  rd_data = rx_holding;
            ADDR_STATUS:  rd_data = status;
            ADDR_CONTROL: rd_data = control;
`ifdef SPI_SLAVE_EOP_EN
            ADDR_EOP:     rd_data = eop_val;
`endif
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_to_cpu_r <= '0;
            irq_r         <= 1'b0;
        end else begin
            if (rd_pulse) data_to_cpu_r <= rd_data;
            irq_r <= |(status & control);
        end
    end

    assign bus.data_to_cpu   = data_to_cpu_r;
    assign bus.irq           = irq_r;
    assign bus.dataavailable = rrdy;
    assign bus.readyfordata  = ~tx_primed;
    assign bus.endofpacket   = eop;
endmodule

// File: tb/tb_wasca_spi_slave.sv
// tb/tb_wasca_spi_slave.sv - self-checking bench for wasca_spi_slave with a transaction-level model
module tb_wasca_spi_slave;
    import wasca_spi_pkg::*;

`ifdef SPI_SLAVE_EOP_EN
    localparam bit EOP_EN = 1'b1;
`else
    localparam bit EOP_EN = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0, SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
    logic MISO, MISO_oe;
    wasca_spi_slave_if bus();

    wasca_spi_slave dut (.clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
                         .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    // Reference model: CPU-visible state changed per whole transaction.
    bit          m_primed, m_rrdy, m_roe, m_toe, m_tur, m_eop;
    logic [15:0] m_hold, m_rx, m_eopv, m_ctrl;
    logic [15:0] mid_q[$];

    function automatic void m_reset();
        m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_eop = 0;
        m_hold = 0; m_rx = 0; m_eopv = 0; m_ctrl = 0;
    endfunction

    function automatic logic [15:0] m_status();
        logic [15:0] s = '0;
        s[9] = m_eop; s[8] = m_roe | m_toe; s[7] = m_rrdy; s[6] = !m_primed; s[5] = !m_primed;
        s[4] = m_toe; s[3] = m_roe; s[2] = m_tur;
        return s;
    endfunction

    function automatic logic [15:0] m_start();
        if (m_primed) begin m_primed = 0; return m_hold; end
        m_tur = 1;
        return 16'hFFFF;
    endfunction

    function automatic void m_done(input logic [15:0] w);
        if (m_rrdy) m_roe = 1;
        m_rx = w; m_rrdy = 1;
    endfunction

    function automatic void m_write(input logic [2:0] a, input logic [15:0] d);
        case (a)
            3'd1: begin
                if (m_primed) m_toe = 1; else begin m_hold = d; m_primed = 1; end
                if (EOP_EN && d == m_eopv) m_eop = 1;
            end
            3'd2: begin m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_eop = 0; end
            3'd3: m_ctrl = d & (EOP_EN ? 16'h03DC : 16'h01DC);
            3'd6: if (EOP_EN) m_eopv = d;
            default: ;
        endcase
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        logic [15:0] r = 16'h0;
        case (a)
            3'd0: begin r = m_rx; m_rrdy = 0; if (EOP_EN && r == m_eopv) m_eop = 1; end
            3'd2: r = m_status();
            3'd3: r = m_ctrl;
            3'd6: r = EOP_EN ? m_eopv : 16'h0;
            default: r = 16'h0;
        endcase
        return r;
    endfunction

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.spi_select = 1; bus.write_n = 0; bus.mem_addr = a; bus.data_from_cpu = d;
        repeat (2) @(negedge clk);
        bus.spi_select = 0; bus.write_n = 1;
        @(negedge clk);
        m_write(a, d);
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.spi_select = 1; bus.read_n = 0; bus.mem_addr = a;
        repeat (2) @(negedge clk);
        d = bus.data_to_cpu;
        bus.spi_select = 0; bus.read_n = 1;
        @(negedge clk);
    endtask

    task automatic spi_frame(input int nbits, input logic [15:0] mosi_w,
                             output logic [15:0] got, output logic [15:0] exp, output logic oe_seen);
        exp = m_start();
        got = '0; oe_seen = 0;
        SS_n = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = mosi_w[15 - (i % 16)];
            repeat (6) @(negedge clk);
            SCLK = 1;
            got = {got[14:0], MISO};
            if (i == 0) oe_seen = MISO_oe;
            repeat (6) @(negedge clk);
            SCLK = 0;
            if (i % 16 == 15) begin m_done(mosi_w); void'(m_start()); end
            if (i == 7 && mid_q.size() > 0) begin
                repeat (4) @(negedge clk);
                while (mid_q.size() > 0) cpu_write(ADDR_TXDATA, mid_q.pop_front());
            end
        end
        repeat (6) @(negedge clk);
        SS_n = 1; MOSI = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic flush();
        logic [15:0] d;
        cpu_read(ADDR_RXDATA, d); void'(m_read(ADDR_RXDATA));
        cpu_write(ADDR_STATUS, 16'h0);
    endtask

    task automatic test_reset();
        logic [15:0] d, e;
        reset_n = 0; m_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if ({MISO, MISO_oe} !== 2'b10) begin n_fail++; $display("FAIL reset_pins: got %b want 10", {MISO, MISO_oe}); end
        n_cmp++; if ({bus.irq, bus.dataavailable, bus.readyfordata, bus.endofpacket} !== 4'b0010) begin n_fail++; $display("FAIL reset_flags: got %b want 0010", {bus.irq, bus.dataavailable, bus.readyfordata, bus.endofpacket}); end
        n_cmp++; if (bus.data_to_cpu !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", bus.data_to_cpu); end
        reset_n = 1;
        repeat (5) @(negedge clk);
        cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
        n_cmp++; if (d !== e || d !== 16'h0060) begin n_fail++; $display("FAIL reset_status: got %h want %h", d, e); end
    endtask

    task automatic test_basic();
        logic [15:0] got, exp, d, e; logic oe;
        cpu_write(ADDR_TXDATA, 16'hA55A);
        spi_frame(16, 16'h1234, got, exp, oe);
        n_cmp++; if (got !== exp || got !== 16'hA55A) begin n_fail++; $display("FAIL basic_miso: got %h want %h", got, exp); end
        n_cmp++; if (oe !== 1'b1) begin n_fail++; $display("FAIL basic_oe: got %b want 1", oe); end
        n_cmp++; if ({MISO, MISO_oe} !== 2'b10) begin n_fail++; $display("FAIL basic_idle_pins: got %b want 10", {MISO, MISO_oe}); end
        n_cmp++; if (bus.dataavailable !== 1'b1) begin n_fail++; $display("FAIL basic_rrdy_set: got %b want 1", bus.dataavailable); end
        cpu_read(ADDR_RXDATA, d); e = m_read(ADDR_RXDATA);
        n_cmp++; if (d !== e || d !== 16'h1234) begin n_fail++; $display("FAIL basic_rxdata: got %h want %h", d, e); end
        n_cmp++; if ({bus.dataavailable, bus.readyfordata} !== {m_rrdy, !m_primed}) begin n_fail++; $display("FAIL basic_rrdy_trdy: got %b want %b", {bus.dataavailable, bus.readyfordata}, {m_rrdy, !m_primed}); end
        cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
        n_cmp++; if (d !== e) begin n_fail++; $display("FAIL basic_status: got %h want %h", d, e); end
    endtask

    task automatic test_overrun();
        logic [15:0] got, exp, d, e; logic oe;
        flush();
        cpu_write(ADDR_CONTROL, 16'h0008);
        spi_frame(16, 16'h0001, got, exp, oe);
        spi_frame(16, 16'h0002, got, exp, oe);
        n_cmp++; if (bus.irq !== (|(m_status() & m_ctrl)) || bus.irq !== 1'b1) begin n_fail++; $display("FAIL overrun_irq: got %b want 1", bus.irq); end
        cpu_read(ADDR_RXDATA, d); e = m_read(ADDR_RXDATA);
        n_cmp++; if (d !== e || d !== 16'h0002) begin n_fail++; $display("FAIL overrun_rxdata: got %h want %h", d, e); end
        cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
        n_cmp++; if (d !== e || d[3] !== 1'b1) begin n_fail++; $display("FAIL overrun_status: got %h want %h", d, e); end
        cpu_read(ADDR_CONTROL, d); e = m_read(ADDR_CONTROL);
        n_cmp++; if (d !== e) begin n_fail++; $display("FAIL overrun_control: got %h want %h", d, e); end
        cpu_write(ADDR_STATUS, 16'h0);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL overrun_irq_clear: got %b want 0", bus.irq); end
        cpu_write(ADDR_CONTROL, 16'h0);
    endtask

    task automatic test_underrun();
        logic [15:0] got, exp, d, e; logic oe;
        flush();
        spi_frame(16, 16'h0F0F, got, exp, oe);
        n_cmp++; if (got !== exp || got !== 16'hFFFF) begin n_fail++; $display("FAIL underrun_miso: got %h want %h", got, exp); end
        cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
        n_cmp++; if (d !== e || d[2] !== 1'b1) begin n_fail++; $display("FAIL underrun_status: got %h want %h", d, e); end
        cpu_write(ADDR_STATUS, 16'h0);
        cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
        n_cmp++; if (d !== e || d[2] !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %h want %h", d, e); end
    endtask

    task automatic test_tx_overrun();
        logic [15:0] got, exp, d, e; logic oe;
        flush();
        cpu_write(ADDR_TXDATA, 16'h1111);
        mid_q.push_back(16'h2222);
        mid_q.push_back(16'h3333);
        spi_frame(16, 16'hC3C3, got, exp, oe);
        n_cmp++; if (got !== exp || got !== 16'h1111) begin n_fail++; $display("FAIL toe_miso: got %h want %h", got, exp); end
        cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
        n_cmp++; if (d !== e || d[4] !== 1'b1) begin n_fail++; $display("FAIL toe_status: got %h want %h", d, e); end
    endtask

    task automatic test_abort();
        logic [15:0] got, exp, d, e; logic oe;
        flush();
        spi_frame(9, 16'h5555, got, exp, oe);
        n_cmp++; if (bus.dataavailable !== 1'b0) begin n_fail++; $display("FAIL abort_rrdy: got %b want 0", bus.dataavailable); end
        cpu_write(ADDR_TXDATA, 16'h6C6C);
        spi_frame(16, 16'hBEEF, got, exp, oe);
        n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL abort_miso: got %h want %h", got, exp); end
        cpu_read(ADDR_RXDATA, d); e = m_read(ADDR_RXDATA);
        n_cmp++; if (d !== e || d !== 16'hBEEF) begin n_fail++; $display("FAIL abort_rxdata: got %h want %h", d, e); end
    endtask

    task automatic test_reset_midframe();
        logic [15:0] got, exp, d, e; logic oe, oe_mid;
        SS_n = 0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            MOSI = i[0];
            repeat (6) @(negedge clk);
            SCLK = 1;
            if (i == 10) oe_mid = MISO_oe;
            repeat (6) @(negedge clk);
            SCLK = 0;
            if (i == 4) begin
                reset_n = 0; repeat (2) @(negedge clk); reset_n = 1; m_reset();
            end
        end
        repeat (6) @(negedge clk);
        SS_n = 1;
        repeat (8) @(negedge clk);
        n_cmp++; if (oe_mid !== 1'b0) begin n_fail++; $display("FAIL midreset_oe: got %b want 0", oe_mid); end
        n_cmp++; if (bus.dataavailable !== 1'b0) begin n_fail++; $display("FAIL midreset_rrdy: got %b want 0", bus.dataavailable); end
        cpu_write(ADDR_TXDATA, 16'h0F0F);
        spi_frame(16, 16'h5A5A, got, exp, oe);
        n_cmp++; if (got !== exp || got !== 16'h0F0F) begin n_fail++; $display("FAIL midreset_miso: got %h want %h", got, exp); end
        cpu_read(ADDR_RXDATA, d); e = m_read(ADDR_RXDATA);
        n_cmp++; if (d !== e) begin n_fail++; $display("FAIL midreset_rxdata: got %h want %h", d, e); end
    endtask

    task automatic test_random();
        logic [15:0] got, exp, d, e, w; logic oe;
        flush();
        cpu_write(ADDR_CONTROL, 16'($urandom));
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(1, 0) == 1) cpu_write(ADDR_TXDATA, 16'($urandom));
            if ($urandom_range(3, 0) == 0) cpu_write(ADDR_TXDATA, 16'($urandom));
            w = 16'($urandom);
            spi_frame(16, w, got, exp, oe);
            n_cmp++; if (got !== exp) begin n_fail++; $display("FAIL rand_miso[%0d]: got %h want %h", k, got, exp); end
            if ($urandom_range(1, 0) == 1) begin
                cpu_read(ADDR_RXDATA, d); e = m_read(ADDR_RXDATA);
                n_cmp++; if (d !== e) begin n_fail++; $display("FAIL rand_rxdata[%0d]: got %h want %h", k, d, e); end
            end
            cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
            n_cmp++; if (d !== e) begin n_fail++; $display("FAIL rand_status[%0d]: got %h want %h", k, d, e); end
            n_cmp++; if (bus.irq !== (|(m_status() & m_ctrl))) begin n_fail++; $display("FAIL rand_irq[%0d]: got %b want %b", k, bus.irq, |(m_status() & m_ctrl)); end
            if ($urandom_range(2, 0) == 0) cpu_write(ADDR_STATUS, 16'h0);
        end
        cpu_write(ADDR_CONTROL, 16'h0);
    endtask

    task automatic test_eop();
        logic [15:0] got, exp, d, e; logic oe;
        flush();
        cpu_write(ADDR_EOP, 16'h00FF);
        cpu_read(ADDR_EOP, d); e = m_read(ADDR_EOP);
        n_cmp++; if (d !== e) begin n_fail++; $display("FAIL eop_value: got %h want %h", d, e); end
        spi_frame(16, 16'h00FF, got, exp, oe);
        n_cmp++; if (bus.endofpacket !== 1'b0) begin n_fail++; $display("FAIL eop_early: got %b want 0", bus.endofpacket); end
        cpu_read(ADDR_RXDATA, d); e = m_read(ADDR_RXDATA);
        n_cmp++; if (d !== e || d !== 16'h00FF) begin n_fail++; $display("FAIL eop_rxdata: got %h want %h", d, e); end
        n_cmp++; if (bus.endofpacket !== m_eop || bus.endofpacket !== EOP_EN) begin n_fail++; $display("FAIL eop_out: got %b want %b", bus.endofpacket, m_eop); end
        cpu_read(ADDR_STATUS, d); e = m_read(ADDR_STATUS);
        n_cmp++; if (d !== e) begin n_fail++; $display("FAIL eop_status: got %h want %h", d, e); end
        cpu_write(ADDR_STATUS, 16'h0);
        n_cmp++; if (bus.endofpacket !== 1'b0) begin n_fail++; $display("FAIL eop_clear: got %b want 0", bus.endofpacket); end
    endtask

    initial begin
        bus.spi_select = 0; bus.read_n = 1; bus.write_n = 1; bus.mem_addr = '0; bus.data_from_cpu = '0;
        test_reset();
        test_basic();
        test_overrun();
        test_underrun();
        test_tx_overrun();
        test_abort();
        test_reset_midframe();
        test_random();
        test_eop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
